// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder
// Description : Builds 32-bit MIPS instruction words from field-level requests
//               and writes them sequentially into instruction memory, one
//               word every two cycles, reporting completion or failure.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [4:0]        op_i,
    input  logic [4:0]        rs_i,
    input  logic [4:0]        rt_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        shamt_i,
    input  logic [15:0]       imm_i,
    input  logic              last_i,
    output logic              memWrite_o,
    output logic [ADDR_W-1:0] memAddr_o,
    output logic [31:0]       memData_o,
    output logic              done_o,
    output logic              error_o,
    output logic [ADDR_W:0]   count_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCEPT = 2'd1,
        S_WRITE  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] c_ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   c_COUNT_ONE = (ADDR_W + 1)'(1);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_memAddr;
    logic [31:0]         r_data;
    logic [ADDR_W:0]     r_count;
    logic                r_error;
    logic                r_last;
    logic                w_hs;
    logic                w_legal;
    logic                w_full;
    logic [31:0]         w_word;

    assign w_hs   = valid_i && (r_state == S_ACCEPT);
    assign w_full = &r_addr;

    // Field-level encoding; unused fields forced to zero, illegal ops flagged
    always_comb begin
        w_legal = 1'b1;
        w_word  = 32'h0000_0000;
        case (op_i)
            5'd0:  w_word = {6'b000000, rs_i, rt_i, rd_i, 5'd0, 6'b100000};
            5'd1:  w_word = {6'b000000, rs_i, rt_i, rd_i, 5'd0, 6'b100010};
            5'd2:  w_word = {6'b000000, rs_i, rt_i, rd_i, 5'd0, 6'b100100};
            5'd3:  w_word = {6'b000000, rs_i, rt_i, rd_i, 5'd0, 6'b100101};
            5'd4:  w_word = {6'b000000, rs_i, rt_i, rd_i, 5'd0, 6'b101010};
            5'd5:  w_word = {6'b000000, 5'd0, rt_i, rd_i, shamt_i, 6'b000000};
            5'd6:  w_word = {6'b000000, 5'd0, rt_i, rd_i, shamt_i, 6'b000010};
            // rs field bit 21 distinguishes rotate from logical shift right
            5'd7:  w_word = {6'b000000, 5'd1, rt_i, rd_i, shamt_i, 6'b000010};
            5'd8:  w_word = {6'b001000, rs_i, rt_i, imm_i};
            5'd9:  w_word = {6'b001100, rs_i, rt_i, imm_i};
            5'd10: w_word = {6'b001101, rs_i, rt_i, imm_i};
            5'd11: w_word = {6'b001010, rs_i, rt_i, imm_i};
            5'd12: w_word = {6'b001110, rs_i, rt_i, imm_i};
            5'd13: w_word = {6'b100011, rs_i, rt_i, imm_i};
            5'd14: w_word = {6'b101011, rs_i, rt_i, imm_i};
            5'd15: w_word = {6'b000100, rs_i, rt_i, imm_i};
            5'd16: w_word = 32'h0000_0000;
            default: w_legal = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; start_i overrides every state
    always_comb begin
        w_next = r_state;
        if (start_i) begin
            w_next = S_ACCEPT;
        end else begin
            case (r_state)
                S_IDLE:   w_next = S_IDLE;
                S_ACCEPT: begin
                    if (w_hs) begin
                        if (w_legal)     w_next = S_WRITE;
                        else if (last_i) w_next = S_DONE;
                    end
                end
                // Top of memory ends the load rather than wrapping to 0
                S_WRITE:  w_next = (r_last || w_full) ? S_DONE : S_ACCEPT;
                S_DONE:   w_next = S_DONE;
                default:  w_next = S_IDLE;
            endcase
        end
    end

    // Address pointer, captured word, word count and sticky error
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_addr    <= '0;
            r_memAddr <= '0;
            r_data    <= 32'h0000_0000;
            r_count   <= '0;
            r_error   <= 1'b0;
            r_last    <= 1'b0;
        end else if (start_i) begin
            r_addr  <= base_i;
            r_count <= '0;
            r_error <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            if (w_hs) begin
                if (w_legal) begin
                    r_data    <= w_word;
                    r_memAddr <= r_addr;
                    r_last    <= last_i;
                end else begin
                    r_error <= 1'b1;
                end
            end
            if (r_state == S_WRITE) begin
                r_addr  <= r_addr + c_ADDR_ONE;
                r_count <= r_count + c_COUNT_ONE;
                if (!r_last && w_full) begin
                    r_error <= 1'b1;
                end
            end
        end
    end

    assign ready_o    = (r_state == S_ACCEPT);
    // A restart in the write cycle abandons that write
    assign memWrite_o = (r_state == S_WRITE) && !start_i;
    assign memAddr_o  = r_memAddr;
    assign memData_o  = r_data;
    assign done_o     = (r_state == S_DONE);
    assign error_o    = r_error;
    assign count_o    = r_count;

endmodule
`default_nettype wire
